// File: rtl/float_divm.sv
// Iterative single-precision divider: result = data_a / data_b, one restoring
// quotient bit per clock, with overflow/underflow/zero flags pulsed on done.
module float_divm (
  input  logic        rst_sys_n,
  input  logic        clk_sys,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        start_trig,
  output logic [3:0]  done,
  output logic [31:0] result
);

  localparam logic [5:0] S_IDLE  = 6'b000001;
  localparam logic [5:0] S_CHECK = 6'b000010;
  localparam logic [5:0] S_EXP   = 6'b000100;
  localparam logic [5:0] S_DIV   = 6'b001000;
  localparam logic [5:0] S_NORM  = 6'b010000;
  localparam logic [5:0] S_OUT   = 6'b100000;

  localparam logic [31:0] SAT_RESULT = 32'h3F80_0000;

  logic [5:0]        state_q,  state_d;
  logic              sign_q,   sign_d;
  logic [7:0]        ea_q,     ea_d;
  logic [7:0]        eb_q,     eb_d;
  logic [23:0]       ma_q,     ma_d;
  logic [23:0]       mb_q,     mb_d;
  logic              div0_q,   div0_d;
  logic              zero_q,   zero_d;
  logic signed [9:0] expon_q,  expon_d;
  logic [24:0]       rem_q,    rem_d;
  logic [25:0]       quo_q,    quo_d;
  logic [4:0]        cnt_q,    cnt_d;
  logic [22:0]       frac_q,   frac_d;
  logic [31:0]       result_q, result_d;
  logic [3:0]        done_q,   done_d;

  // Restoring step and normalization helpers, used only in their own states.
  logic              rem_ge;
  logic [24:0]       rem_sub;
  logic [24:0]       rem_nxt;
  logic [22:0]       norm_frac;
  logic              norm_rnd;
  logic signed [9:0] norm_exp;
  logic              is_over;
  logic              is_under;

  assign rem_ge    = rem_q >= {1'b0, mb_q};
  assign rem_sub   = rem_q - {1'b0, mb_q};
  assign rem_nxt   = rem_ge ? rem_sub : rem_q;
  assign norm_frac = quo_q[25] ? quo_q[24:2] : quo_q[23:1];
  assign norm_rnd  = quo_q[25] ? quo_q[1]    : quo_q[0];
  assign norm_exp  = quo_q[25] ? expon_q     : expon_q - 10'sd1;

  // The exponent is never computed on the zero/divide-by-zero path, so its
  // range tests only apply to operations that went through EXP.
  assign is_over  = div0_q | (~zero_q & (expon_q >= 10'sd255));
  assign is_under = ~div0_q & ~zero_q & (expon_q <= 10'sd0);

  // NOTE: every *_d gets a default before the case, so no branch can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    div0_d   = div0_q;
    zero_d   = zero_q;
    expon_d  = expon_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    frac_d   = frac_q;
    result_d = result_q;
    done_d   = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (start_trig) begin
          sign_d  = data_a[31] ^ data_b[31];
          ea_d    = data_a[30:23];
          eb_d    = data_b[30:23];
          ma_d    = (data_a[30:0] == 31'd0) ? 24'd0 : {1'b1, data_a[22:0]};
          mb_d    = (data_b[30:0] == 31'd0) ? 24'd0 : {1'b1, data_b[22:0]};
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        div0_d  = (mb_q == 24'd0);
        zero_d  = (mb_q != 24'd0) && (ma_q == 24'd0);
        state_d = ((mb_q == 24'd0) || (ma_q == 24'd0)) ? S_OUT : S_EXP;
      end
      S_EXP: begin
        expon_d = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
        rem_d   = {1'b0, ma_q};
        quo_d   = 26'd0;
        cnt_d   = 5'd0;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = rem_nxt << 1;
        quo_d = {quo_q[24:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) state_d = S_NORM;
      end
      S_NORM: begin
        // Round half up on the first dropped bit; a carry out of the
        // fraction bumps the exponent instead.
        frac_d  = norm_frac;
        expon_d = norm_exp;
        if (norm_rnd) begin
          if (&norm_frac) begin
            frac_d  = 23'd0;
            expon_d = norm_exp + 10'sd1;
          end else begin
            frac_d = norm_frac + 23'd1;
          end
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (is_over) begin
          done_d   = 4'b1001;
          result_d = SAT_RESULT;
        end else if (is_under) begin
          done_d   = 4'b0101;
          result_d = SAT_RESULT;
        end else if (zero_q) begin
          done_d   = 4'b0011;
          result_d = 32'h0000_0000;
        end else begin
          done_d   = 4'b0001;
          result_d = {sign_q, expon_q[7:0], frac_q};
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      ea_q     <= 8'd0;
      eb_q     <= 8'd0;
      ma_q     <= 24'd0;
      mb_q     <= 24'd0;
      div0_q   <= 1'b0;
      zero_q   <= 1'b0;
      expon_q  <= 10'sd0;
      rem_q    <= 25'd0;
      quo_q    <= 26'd0;
      cnt_q    <= 5'd0;
      frac_q   <= 23'd0;
      result_q <= 32'd0;
      done_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      div0_q   <= div0_d;
      zero_q   <= zero_d;
      expon_q  <= expon_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      frac_q   <= frac_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_float_divm.sv
// Scoreboard bench for float_divm: directed corner cases, reset abort and
// random normal operands against an integer-division reference model.
module tb_float_divm;

  logic        rst_sys_n;
  logic        clk_sys;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        start_trig;
  logic [3:0]  done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  dn;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;
  int   pulses;
  int   exp_pulses;

  float_divm dut (
    .rst_sys_n  (rst_sys_n),
    .clk_sys    (clk_sys),
    .data_a     (data_a),
    .data_b     (data_b),
    .start_trig (start_trig),
    .done       (done),
    .result     (result)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (done[0]) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [3:0] dn,
                                  output int lat);
    logic [23:0] ma;
    logic [23:0] mb;
    logic [63:0] q;
    logic [22:0] frac;
    logic        rnd;
    int          ex;
    ma = (a[30:0] == 31'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (b[30:0] == 31'd0) ? 24'd0 : {1'b1, b[22:0]};
    if (mb == 24'd0) begin
      res = 32'h3F80_0000; dn = 4'b1001; lat = 2;
    end else if (ma == 24'd0) begin
      res = 32'h0; dn = 4'b0011; lat = 2;
    end else begin
      lat = 30;
      ex  = int'(a[30:23]) - int'(b[30:23]) + 127;
      q   = ({40'd0, ma} << 25) / {40'd0, mb};
      if (q[25]) begin
        frac = q[24:2]; rnd = q[1];
      end else begin
        frac = q[23:1]; rnd = q[0]; ex = ex - 1;
      end
      if (rnd) begin
        if (frac == 23'h7FFFFF) begin
          frac = 23'd0; ex = ex + 1;
        end else begin
          frac = frac + 23'd1;
        end
      end
      if (ex >= 255) begin
        res = 32'h3F80_0000; dn = 4'b1001;
      end else if (ex <= 0) begin
        res = 32'h3F80_0000; dn = 4'b0101;
      end else begin
        res = {a[31] ^ b[31], ex[7:0], frac}; dn = 4'b0001;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge where isdone was seen, so the
  // next call starts in the very cycle isdone is high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, input int rst_at);
    exp_t e;
    exp_t g;
    int   n;
    bit   got;
    bit   aborted;
    ref_div(a, b, e.res, e.dn, e.lat);
    if (rst_at == 0) begin
      sb_q.push_back(e);
      exp_pulses++;
    end
    data_a = a; data_b = b; start_trig = 1'b1;
    @(posedge clk_sys);
    #1;
    start_trig = 1'b0;
    data_a = $urandom; data_b = $urandom;
    n = 0; got = 1'b0; aborted = 1'b0;
    while (n < 40 && !got && !aborted) begin
      @(posedge clk_sys);
      n++;
      @(negedge clk_sys);
      if (n == inject_at) begin
        data_a = 32'h3F80_0000; data_b = 32'h4040_0000; start_trig = 1'b1;
      end else begin
        start_trig = 1'b0;
      end
      if (n == rst_at) begin
        rst_sys_n = 1'b0;
        #1;
        check("rst_result", result, 32'h0);
        check("rst_done", {28'd0, done}, 32'h0);
        repeat (2) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk_sys);
          check("rst_no_done", {28'd0, done}, 32'h0);
        end
        aborted = 1'b1;
      end else if (done[0]) begin
        got = 1'b1;
      end
    end
    if (!aborted) begin
      g = sb_q.pop_front();
      if (!got) begin
        check("timeout", 32'd0, 32'd1);
      end else begin
        check("result", result, g.res);
        check("done", {28'd0, done}, {28'd0, g.dn});
        check("latency", n, g.lat);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; exp_pulses = 0; pulses = 0;
    rst_sys_n = 1'b0; start_trig = 1'b0; data_a = 32'h0; data_b = 32'h0;
    repeat (3) @(negedge clk_sys);
    check("reset_result", result, 32'h0);
    check("reset_done", {28'd0, done}, 32'h0);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);

    run_op(32'h40C0_0000, 32'h4000_0000, 10, 0);
    check("six_by_two", result, 32'h4040_0000);
    run_op(32'h3F80_0000, 32'h4040_0000, 0, 0);
    check("one_third", result, 32'h3EAA_AAAB);
    run_op(32'hC0F0_0000, 32'h4020_0000, 0, 0);
    check("neg_div", result, 32'hC040_0000);
    run_op(32'h0000_0000, 32'h40A0_0000, 0, 0);
    check("zero_flags", {28'd0, done}, 32'h3);
    run_op(32'h40A0_0000, 32'h0000_0000, 0, 0);
    check("div0_flags", {28'd0, done}, 32'h9);
    run_op(32'h0000_0000, 32'h0000_0000, 0, 0);
    run_op(32'h7F00_0000, 32'h3E80_0000, 0, 0);
    check("over_flags", {28'd0, done}, 32'h9);
    run_op(32'h0080_0000, 32'h4000_0000, 0, 0);
    check("under_flags", {28'd0, done}, 32'h5);
    run_op(32'h40C0_0000, 32'h4000_0000, 0, 0);
    run_op(32'h40C0_0000, 32'h4000_0000, 0, 15);
    run_op(32'h3F80_0000, 32'h4040_0000, 0, 0);
    check("after_reset", result, 32'h3EAA_AAAB);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = {$urandom_range(1, 0) == 1, 8'($urandom_range(190, 64)), 23'($urandom)};
      b = {$urandom_range(1, 0) == 1, 8'($urandom_range(190, 64)), 23'($urandom)};
      run_op(a, b, 0, 0);
    end

    repeat (5) @(negedge clk_sys);
    check("pulse_count", pulses, exp_pulses);
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
